// File: rtl/idecode.sv
// rtl/idecode.sv - RV64I + Zicsr registered decode stage (ID/EX pipeline register)
//
// Decodes one 32-bit instruction per cycle into fields, a sign-extended
// immediate, and ALU/memory/branch/CSR/trap controls. All outputs are registered.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   flush, stall         squash (two-edge bubble), hold all outputs
//   instr, pc            fetched instruction word and its PC
//   regfile_rs1/rs2      register read data (reserved, no effect on outputs)
//   opcode..funct7       raw instruction fields
//   imm, pc_out          decoded immediate, registered PC
//   alu_op, trap_cause   ALU operation, mcause code
//   csr_addr, is_csr, csr_read, csr_write
//   trap, reg_write_enable, mem_read, mem_write, is_branch, jump, use_pc
module idecode #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            flush,
   input  logic            stall,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] regfile_rs1,
   input  logic [XLEN-1:0] regfile_rs2,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_out,
   output logic [3:0]      alu_op,
   output logic [3:0]      trap_cause,
   output logic [11:0]     csr_addr,
   output logic            is_csr,
   output logic            csr_read,
   output logic            csr_write,
   output logic            trap,
   output logic            reg_write_enable,
   output logic            mem_read,
   output logic            mem_write,
   output logic            is_branch,
   output logic            jump,
   output logic            use_pc
);

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [6:0]      opcode;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [3:0]      alu_op;
      logic [3:0]      trap_cause;
      logic [11:0]     csr_addr;
      logic            is_csr;
      logic            csr_read;
      logic            csr_write;
      logic            trap;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            is_branch;
      logic            jump;
      logic            use_pc;
   } dec_t;

   dec_t d;
   dec_t q;
   logic flush_pending;
   logic illegal;

   logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, csr_uimm;
   logic [6:0]      f7;
   logic [2:0]      f3;

   assign f7 = instr[31:25];
   assign f3 = instr[14:12];

   assign i_imm    = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign s_imm    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign b_imm    = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm    = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
   assign j_imm    = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign csr_uimm = {{(XLEN-5){1'b0}}, instr[19:15]};

   // Register read data is carried for a later operand-forwarding stage.
   logic unused_regfile;
   assign unused_regfile = ^{regfile_rs1, regfile_rs2};

   always_comb begin
      d          = '0;
      illegal    = 1'b0;
      d.opcode   = instr[6:0];
      d.rd       = instr[11:7];
      d.rs1      = instr[19:15];
      d.rs2      = instr[24:20];
      d.funct3   = f3;
      d.funct7   = f7;
      d.pc       = pc;

      if (instr[1:0] != 2'b11) begin
         illegal = 1'b1;
      end else begin
         case (instr[6:0])
            OPC_OP: begin
               d.reg_write = 1'b1;
               case ({f7, f3})
                  {F7_BASE, 3'b000}: d.alu_op = ALU_ADD;
                  {F7_ALT,  3'b000}: d.alu_op = ALU_SUB;
                  {F7_BASE, 3'b001}: d.alu_op = ALU_SLL;
                  {F7_BASE, 3'b010}: d.alu_op = ALU_SLT;
                  {F7_BASE, 3'b011}: d.alu_op = ALU_SLTU;
                  {F7_BASE, 3'b100}: d.alu_op = ALU_XOR;
                  {F7_BASE, 3'b101}: d.alu_op = ALU_SRL;
                  {F7_ALT,  3'b101}: d.alu_op = ALU_SRA;
                  {F7_BASE, 3'b110}: d.alu_op = ALU_OR;
                  {F7_BASE, 3'b111}: d.alu_op = ALU_AND;
                  default:           illegal  = 1'b1;
               endcase
            end
            OPC_OP32: begin
               d.reg_write = 1'b1;
               case ({f7, f3})
                  {F7_BASE, 3'b000}: d.alu_op = ALU_ADD;
                  {F7_ALT,  3'b000}: d.alu_op = ALU_SUB;
                  {F7_BASE, 3'b001}: d.alu_op = ALU_SLL;
                  {F7_BASE, 3'b101}: d.alu_op = ALU_SRL;
                  {F7_ALT,  3'b101}: d.alu_op = ALU_SRA;
                  default:           illegal  = 1'b1;
               endcase
            end
            OPC_OP_IMM: begin
               d.reg_write = 1'b1;
               d.imm       = i_imm;
               case (f3)
                  3'b000: d.alu_op = ALU_ADD;
                  3'b010: d.alu_op = ALU_SLT;
                  3'b011: d.alu_op = ALU_SLTU;
                  3'b100: d.alu_op = ALU_XOR;
                  3'b110: d.alu_op = ALU_OR;
                  3'b111: d.alu_op = ALU_AND;
                  // 64-bit shifts: shamt is instr[25:20], so only [31:26] is checked.
                  3'b001: if (instr[31:26] == 6'b000000) d.alu_op = ALU_SLL; else illegal = 1'b1;
                  default: begin
                     if (instr[31:26] == 6'b000000)      d.alu_op = ALU_SRL;
                     else if (instr[31:26] == 6'b010000) d.alu_op = ALU_SRA;
                     else                                illegal  = 1'b1;
                  end
               endcase
            end
            OPC_OP_IMM32: begin
               d.reg_write = 1'b1;
               d.imm       = i_imm;
               case (f3)
                  3'b000: d.alu_op = ALU_ADD;
                  3'b001: if (f7 == F7_BASE) d.alu_op = ALU_SLL; else illegal = 1'b1;
                  3'b101: begin
                     if (f7 == F7_BASE)     d.alu_op = ALU_SRL;
                     else if (f7 == F7_ALT) d.alu_op = ALU_SRA;
                     else                   illegal  = 1'b1;
                  end
                  default: illegal = 1'b1;
               endcase
            end
            OPC_LOAD: begin
               if (f3 == 3'b111) illegal = 1'b1;
               d.alu_op    = ALU_ADD;
               d.mem_read  = 1'b1;
               d.reg_write = 1'b1;
               d.imm       = i_imm;
            end
            OPC_STORE: begin
               if (f3[2]) illegal = 1'b1;
               d.alu_op    = ALU_ADD;
               d.mem_write = 1'b1;
               d.imm       = s_imm;
            end
            OPC_BRANCH: begin
               if (f3[2:1] == 2'b01) illegal = 1'b1;
               d.is_branch = 1'b1;
               d.use_pc    = 1'b1;
               d.imm       = b_imm;
            end
            OPC_JAL: begin
               d.jump      = 1'b1;
               d.reg_write = 1'b1;
               d.use_pc    = 1'b1;
               d.alu_op    = ALU_ADD;
               d.imm       = j_imm;
            end
            OPC_JALR: begin
               if (f3 != 3'b000) illegal = 1'b1;
               d.jump      = 1'b1;
               d.reg_write = 1'b1;
               d.alu_op    = ALU_ADD;
               d.imm       = i_imm;
            end
            OPC_LUI: begin
               d.reg_write = 1'b1;
               d.imm       = u_imm;
            end
            OPC_AUIPC: begin
               d.reg_write = 1'b1;
               d.use_pc    = 1'b1;
               d.alu_op    = ALU_ADD;
               d.imm       = u_imm;
            end
            OPC_SYSTEM: begin
               case (f3)
                  3'b000: begin
                     case (instr)
                        32'h0000_0073: begin d.trap = 1'b1; d.trap_cause = 4'd11; end
                        32'h0010_0073: begin d.trap = 1'b1; d.trap_cause = 4'd3;  end
                        32'h3020_0073: d.jump = 1'b1;
                        32'h1050_0073: ;
                        default:       illegal = 1'b1;
                     endcase
                  end
                  3'b100: illegal = 1'b1;
                  default: begin
                     d.is_csr    = 1'b1;
                     d.csr_addr  = instr[31:20];
                     d.reg_write = (instr[11:7] != 5'd0);
                     d.imm       = f3[2] ? csr_uimm : '0;
                     // CSRRW skips the read when rd=x0; CSRRS/RC skip the write when the mask is zero.
                     if (f3[1:0] == 2'b01) begin
                        d.csr_write = 1'b1;
                        d.csr_read  = (instr[11:7] != 5'd0);
                     end else begin
                        d.csr_read  = 1'b1;
                        d.csr_write = (instr[19:15] != 5'd0);
                     end
                  end
               endcase
            end
            default: illegal = 1'b1;
         endcase
      end

      // Illegal instructions keep raw fields and PC but drop every control.
      if (illegal) begin
         d.imm        = '0;
         d.alu_op     = ALU_NONE;
         d.csr_addr   = '0;
         d.is_csr     = 1'b0;
         d.csr_read   = 1'b0;
         d.csr_write  = 1'b0;
         d.reg_write  = 1'b0;
         d.mem_read   = 1'b0;
         d.mem_write  = 1'b0;
         d.is_branch  = 1'b0;
         d.jump       = 1'b0;
         d.use_pc     = 1'b0;
         d.trap       = 1'b1;
         d.trap_cause = 4'd2;
      end
   end

   // A flush squashes two edges: the current slot and the wrong-path fetch behind it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q             <= '0;
         flush_pending <= 1'b0;
      end else if (flush) begin
         q             <= '0;
         flush_pending <= 1'b1;
      end else if (flush_pending) begin
         q             <= '0;
         flush_pending <= 1'b0;
      end else if (!stall) begin
         q <= d;
      end
   end

   assign opcode           = q.opcode;
   assign rd               = q.rd;
   assign rs1              = q.rs1;
   assign rs2              = q.rs2;
   assign funct3           = q.funct3;
   assign funct7           = q.funct7;
   assign imm              = q.imm;
   assign pc_out           = q.pc;
   assign alu_op           = q.alu_op;
   assign trap_cause       = q.trap_cause;
   assign csr_addr         = q.csr_addr;
   assign is_csr           = q.is_csr;
   assign csr_read         = q.csr_read;
   assign csr_write        = q.csr_write;
   assign trap             = q.trap;
   assign reg_write_enable = q.reg_write;
   assign mem_read         = q.mem_read;
   assign mem_write        = q.mem_write;
   assign is_branch        = q.is_branch;
   assign jump             = q.jump;
   assign use_pc           = q.use_pc;

endmodule

// File: tb/tb_idecode.sv
// tb/tb_idecode.sv - directed self-checking bench for idecode
module tb_idecode;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        stall;
   logic [31:0] instr;
   logic [63:0] pc;
   logic [63:0] regfile_rs1;
   logic [63:0] regfile_rs2;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [63:0] imm;
   logic [63:0] pc_out;
   logic [3:0]  alu_op;
   logic [3:0]  trap_cause;
   logic [11:0] csr_addr;
   logic        is_csr;
   logic        csr_read;
   logic        csr_write;
   logic        trap;
   logic        reg_write_enable;
   logic        mem_read;
   logic        mem_write;
   logic        is_branch;
   logic        jump;
   logic        use_pc;

   int checks = 0;
   int errors = 0;

   idecode #(.XLEN(64)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .stall(stall),
      .instr(instr), .pc(pc), .regfile_rs1(regfile_rs1), .regfile_rs2(regfile_rs2),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
      .imm(imm), .pc_out(pc_out), .alu_op(alu_op), .trap_cause(trap_cause),
      .csr_addr(csr_addr), .is_csr(is_csr), .csr_read(csr_read), .csr_write(csr_write),
      .trap(trap), .reg_write_enable(reg_write_enable), .mem_read(mem_read),
      .mem_write(mem_write), .is_branch(is_branch), .jump(jump), .use_pc(use_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present an instruction, let one rising edge capture it, sample 1ns later.
   task automatic step(input logic [31:0] i, input logic [63:0] p);
      instr = i;
      pc    = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn      = 1'b0;
      flush       = 1'b0;
      stall       = 1'b0;
      instr       = 32'h0000_0013;
      pc          = 64'h0;
      regfile_rs1 = 64'hDEAD_BEEF_0000_1111;
      regfile_rs2 = 64'h1234_5678_9ABC_DEF0;
      #3;
      chk("reset_rw", {63'b0, reg_write_enable}, 64'd0);
      chk("reset_opcode", {57'b0, opcode}, 64'd0);
      chk("reset_imm", imm, 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      step(32'h003100B3, 64'h0000_0000_8000_0000);
      chk("add_rw", {63'b0, reg_write_enable}, 64'd1);
      chk("add_alu", {60'b0, alu_op}, 64'd1);
      chk("add_rd", {59'b0, rd}, 64'd1);
      chk("add_rs1", {59'b0, rs1}, 64'd2);
      chk("add_rs2", {59'b0, rs2}, 64'd3);
      chk("add_pc", pc_out, 64'h0000_0000_8000_0000);
      chk("add_imm", imm, 64'd0);

      step(32'h40628233, 64'h0000_0000_8000_0004);
      chk("sub_alu", {60'b0, alu_op}, 64'd2);
      chk("sub_rd", {59'b0, rd}, 64'd4);
      chk("sub_rs1", {59'b0, rs1}, 64'd5);
      chk("sub_rs2", {59'b0, rs2}, 64'd6);
      chk("sub_f7", {57'b0, funct7}, 64'h20);

      step(32'h009443B3, 64'h0000_0000_8000_0008);
      chk("xor_alu", {60'b0, alu_op}, 64'd5);

      step(32'h06400093, 64'h0000_0000_8000_000C);
      chk("addi_imm", imm, 64'h64);
      chk("addi_alu", {60'b0, alu_op}, 64'd1);
      chk("addi_rw", {63'b0, reg_write_enable}, 64'd1);

      step(32'hFFF0C093, 64'h0000_0000_8000_0010);
      chk("xori_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("xori_alu", {60'b0, alu_op}, 64'd5);

      step(32'h00812283, 64'h0000_0000_8000_0014);
      chk("lw_mem_read", {63'b0, mem_read}, 64'd1);
      chk("lw_imm", imm, 64'd8);
      chk("lw_alu", {60'b0, alu_op}, 64'd1);
      chk("lw_f3", {61'b0, funct3}, 64'd2);

      step(32'h00322623, 64'h0000_0000_8000_0018);
      chk("sw_mem_write", {63'b0, mem_write}, 64'd1);
      chk("sw_rw", {63'b0, reg_write_enable}, 64'd0);
      chk("sw_imm", imm, 64'hC);

      step(32'h00209863, 64'h0000_0000_8000_001C);
      chk("bne_branch", {63'b0, is_branch}, 64'd1);
      chk("bne_use_pc", {63'b0, use_pc}, 64'd1);
      chk("bne_imm", imm, 64'h10);
      chk("bne_alu", {60'b0, alu_op}, 64'd0);

      step(32'h123450B7, 64'h0000_0000_8000_0020);
      chk("lui_imm", imm, 64'h0000_0000_1234_5000);
      chk("lui_alu", {60'b0, alu_op}, 64'd0);

      step(32'hFFFFF0B7, 64'h0000_0000_8000_0024);
      chk("lui_neg_imm", imm, 64'hFFFF_FFFF_FFFF_F000);

      step(32'h00001117, 64'h8000_0000_0000_1000);
      chk("auipc_alu", {60'b0, alu_op}, 64'd1);
      chk("auipc_use_pc", {63'b0, use_pc}, 64'd1);
      chk("auipc_imm", imm, 64'h1000);
      chk("auipc_pc", pc_out, 64'h8000_0000_0000_1000);

      step(32'h300110F3, 64'h0000_0000_8000_0028);
      chk("csrrw_is_csr", {63'b0, is_csr}, 64'd1);
      chk("csrrw_addr", {52'b0, csr_addr}, 64'h300);
      chk("csrrw_read", {63'b0, csr_read}, 64'd1);
      chk("csrrw_write", {63'b0, csr_write}, 64'd1);
      chk("csrrw_rw", {63'b0, reg_write_enable}, 64'd1);

      step(32'h00000073, 64'h0000_0000_8000_002C);
      chk("ecall_trap", {63'b0, trap}, 64'd1);
      chk("ecall_cause", {60'b0, trap_cause}, 64'd11);
      chk("ecall_rw", {63'b0, reg_write_enable}, 64'd0);

      step(32'hFFFFFFFF, 64'h0000_0000_8000_0030);
      chk("illegal_trap", {63'b0, trap}, 64'd1);
      chk("illegal_cause", {60'b0, trap_cause}, 64'd2);
      chk("illegal_imm", imm, 64'd0);
      chk("illegal_alu", {60'b0, alu_op}, 64'd0);
      chk("illegal_opcode", {57'b0, opcode}, 64'h7F);

      stall = 1'b1;
      step(32'h003100B3, 64'h0000_0000_8000_0034);
      chk("stall_trap", {63'b0, trap}, 64'd1);
      chk("stall_opcode", {57'b0, opcode}, 64'h7F);
      chk("stall_pc", pc_out, 64'h0000_0000_8000_0030);
      stall = 1'b0;

      flush = 1'b1;
      step(32'h06400093, 64'h0000_0000_8000_0038);
      flush = 1'b0;
      chk("flush1_rw", {63'b0, reg_write_enable}, 64'd0);
      chk("flush1_trap", {63'b0, trap}, 64'd0);
      chk("flush1_opcode", {57'b0, opcode}, 64'd0);
      step(32'h06400093, 64'h0000_0000_8000_0038);
      chk("flush2_rw", {63'b0, reg_write_enable}, 64'd0);
      chk("flush2_imm", imm, 64'd0);
      chk("flush2_pc", pc_out, 64'd0);
      step(32'h00000013, 64'h0000_0000_8000_003C);
      chk("nop_rw", {63'b0, reg_write_enable}, 64'd1);
      chk("nop_alu", {60'b0, alu_op}, 64'd1);
      chk("nop_pc", pc_out, 64'h0000_0000_8000_003C);

      #2;
      resetn = 1'b0;
      #1;
      chk("async_reset_rw", {63'b0, reg_write_enable}, 64'd0);
      chk("async_reset_alu", {60'b0, alu_op}, 64'd0);
      resetn = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- RV64I + Zicsr instruction decode stage, registered (ID/EX pipeline register).
- Takes a fetched 32-bit instruction and its PC, extracts fields, sign-extends immediates, produces ALU/memory/branch/CSR/trap control.
- Supports stall (hold) and flush (bubble insertion).
- Sits between ifetch and execute.

Parameters:
- XLEN, 64, datapath/PC/immediate width. Only 64 needs support.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  squash: insert bubble
- stall  in  1  hold all outputs
- instr  in  32  instruction word
- pc  in  XLEN  PC of instr
- regfile_rs1  in  XLEN  rs1 read data; reserved, no effect on outputs
- regfile_rs2  in  XLEN  rs2 read data; reserved, no effect on outputs
- opcode  out  7  instr[6:0]
- rd  out  5  instr[11:7]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- imm  out  XLEN  sign-extended immediate
- pc_out  out  XLEN  registered pc
- alu_op  out  4  ALU operation
- trap_cause  out  4  mcause code when trap=1, else 0
- csr_addr  out  12  instr[31:20] for CSR ops, else 0
- is_csr  out  1  Zicsr instruction
- csr_read  out  1  CSR is read
- csr_write  out  1  CSR is written
- trap  out  1  exception raised
- reg_write_enable  out  1  writes rd
- mem_read  out  1  load
- mem_write  out  1  store
- is_branch  out  1  conditional branch
- jump  out  1  JAL/JALR/MRET
- use_pc  out  1  ALU operand A is pc (AUIPC, JAL, branches)

Behaviour:
- All outputs registered. Latency 1: instr sampled at edge N, outputs valid after edge N.
- Bubble: all outputs 0 (imm=0, alu_op=0, trap=0, all fields 0).
- Reset (resetn=0, async) forces the bubble and clears flush_pending.
- Priority per edge: reset > flush/flush_pending > stall > decode.
- Flush: at an edge with flush=1, load bubble and set flush_pending=1.
- At the next edge, load bubble again (the following instr is wrong-path) and clear flush_pending. Decode resumes on the second edge after flush.
- Stall=1 (no flush): all outputs hold.
- alu_op encoding: 0000 NONE/pass-imm, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLT, 1010 SLTU.
- OP (0110011), OP-32 (0111011): R-type. funct7 is 0000000, or 0100000 for SUB/SRA (SUBW/SRAW); other funct7 is illegal. reg_write=1, imm=0.
- OP-IMM (0010011), OP-IMM-32 (0011011): I-imm. Shifts use instr[31:26] (64-bit) or [31:25] (32-bit); bit 30 selects SRA; other upper bits are illegal. No SUBI. reg_write=1.
- LOAD (0000011): alu ADD, mem_read=1, reg_write=1, I-imm. funct3=111 is illegal.
- STORE (0100011): alu ADD, mem_write=1, S-imm. funct3>011 is illegal.
- BRANCH (1100011): is_branch=1, use_pc=1, alu 0000, B-imm. funct3 010/011 are illegal.
- JAL (1101111): jump=1, reg_write=1, use_pc=1, alu ADD, J-imm.
- JALR (1100111): jump=1, reg_write=1, alu ADD, I-imm. funct3≠000 is illegal.
- LUI (0110111): alu 0000, reg_write=1, imm = sext(instr[31:12]<<12).
- AUIPC (0010111): alu ADD, use_pc=1, reg_write=1, same U-imm.
- SYSTEM (1110011), funct3≠000/100: is_csr=1, csr_addr=instr[31:20], reg_write=(rd≠0).
  - CSRRW/CSRRWI: csr_write=1, csr_read=(rd≠0).
  - CSRRS/RC(+I): csr_read=1, csr_write=(rs1/uimm≠0).
  - imm = zero-extended uimm for the I forms.
- SYSTEM, funct3=000:
  - ECALL (0x00000073): trap=1, cause 11.
  - EBREAK (0x00100073): trap=1, cause 3.
  - MRET (0x30200073): jump=1.
  - WFI (0x10500073): no-op.
  - Anything else is illegal.
- Illegal (unknown opcode, instr[1:0]≠11, invalid funct): trap=1, cause 2. All other controls 0, imm=0. Field outputs still reflect instr.
- Field outputs and pc_out are always the raw values for decoded (non-bubble) instructions.
- ADDI x0,x0,0 (0x00000013) decodes as a normal ADDI: reg_write=1. x0 write suppression belongs to writeback.

Test Plan:
- Reset, then ADD 0x003100B3 -> reg_write=1, alu 0001; SUB 0x40628233 -> alu 0010; XOR 0x009443B3 -> alu 0101.
- ADDI imm 100 -> imm 0x64, alu 0001. XORI -1 -> imm 0xFFFF_FFFF_FFFF_FFFF, alu 0101. LW 8(x2) -> mem_read=1, imm 8. SW x3,12(x4) -> mem_write=1, reg_write=0, imm 0xC.
- LUI x1,0x12345 -> imm 0x12345000, alu 0000. AUIPC -> alu 0001, use_pc=1.
- CSRRW x1,0x300,x2 -> is_csr, csr_addr 0x300, csr_read=csr_write=reg_write=1.
- ECALL -> trap=1, cause 11, reg_write=0. Instr 0xFFFFFFFF -> trap=1, cause 2, imm 0, alu 0.
- Stall=1 with new instr -> outputs unchanged. Flush pulse with ADDI held -> bubble for 2 edges, then NOP 0x13 -> reg_write=1, alu 0001.
